instr_mem_responder: RTL

Instruction-memory responder serving the fetch stage's req/gnt/rvalid instruction bus. Accepts word reads, grants under an outstanding-request limit, and returns data in order after a fixed latency with an optional error flag. Includes a program-load write port for boot loading and test benches. Sits between the fetch stage and on-chip instruction RAM, or stands in for it in simulation.

---
 rtl/instr_mem_pkg.sv | 14 +
 rtl/instr_mem_delay_line.sv | 45 ++++
 rtl/instr_mem_responder.sv | 104 ++++++++++
 3 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package instr_mem_pkg;

   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] data;
   } instr_rsp_t;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   localparam instr_rsp_t RSP_IDLE = '{valid: 1'b0, err: 1'b0, data: 32'h0};

endpackage

// File: rtl/instr_mem_delay_line.sv
// Response delay line of DEPTH stages; DEPTH == 0 is a wire.
// Payload only loads with a valid beat so the last stage holds the last response.
module instr_mem_delay_line
   import instr_mem_pkg::*;
#(
   parameter int DEPTH = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  instr_rsp_t d,
   output instr_rsp_t q
);

   generate
      if (DEPTH == 0) begin : g_pass
         logic unused_ctl;
         assign unused_ctl = clk ^ rst;
         assign q = d;
      end else begin : g_pipe
         instr_rsp_t stg [DEPTH];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) stg[i] <= RSP_IDLE;
            end else begin
               stg[0].valid <= d.valid;
               if (d.valid) begin
                  stg[0].err  <= d.err;
                  stg[0].data <= d.data;
               end
               for (int i = 1; i < DEPTH; i++) begin
                  stg[i].valid <= stg[i-1].valid;
                  if (stg[i-1].valid) begin
                     stg[i].err  <= stg[i-1].err;
                     stg[i].data <= stg[i-1].data;
                  end
               end
            end
         end

         assign q = stg[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder on a req/gnt/rvalid bus with a program-load port.
// Define INSTR_MEM_ERR_EN to flag out-of-range / odd addresses instead of wrapping.
module instr_mem_responder
   import instr_mem_pkg::*;
#(
   parameter int          MEM_WORDS       = 1024,
   parameter logic [31:0] BASE_ADDR       = 32'h0,
   parameter int          LATENCY         = 1,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        load_we_i,
   input  logic [31:0] load_addr_i,
   input  logic [31:0] load_wdata_i
);

   localparam int              AW      = $clog2(MEM_WORDS);
   localparam int              CNT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
   localparam logic [32:0]     SPAN    = 33'(MEM_WORDS) << 2;

   logic [31:0]      mem [MEM_WORDS];
   logic [CNT_W-1:0] outstanding;
   logic [31:0]      rd_off, ld_off;
   logic [AW-1:0]    rd_idx, ld_idx;
   logic             rd_err, ld_ok;
   instr_rsp_t       rsp_q, rsp_out;

   assign rd_off = instr_addr_i - BASE_ADDR;
   assign ld_off = load_addr_i - BASE_ADDR;
   assign rd_idx = rd_off[AW+1:2];
   assign ld_idx = ld_off[AW+1:2];

`ifdef INSTR_MEM_ERR_EN
   assign rd_err = (instr_addr_i < BASE_ADDR) | ({1'b0, rd_off} >= SPAN) | instr_addr_i[0];
   assign ld_ok  = (load_addr_i >= BASE_ADDR) & ({1'b0, ld_off} < SPAN);
`else
   assign rd_err = 1'b0;
   assign ld_ok  = 1'b1;
`endif

   // Upper offset bits only matter for range checks; byte-lane bits never do.
   logic unused_addr;
   assign unused_addr = ^{rd_off, ld_off};

   // Credits free only on the edge after a response leaves: no bypass path.
   assign instr_gnt_o = instr_req_i & ~rst & (outstanding < MAX_CNT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding <= '0;
      end else begin
         case ({instr_gnt_o, instr_rvalid_o})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (load_we_i && ld_ok) mem[ld_idx] <= load_wdata_i;
   end

   // First response stage samples the array before this edge's load lands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_q <= RSP_IDLE;
      end else begin
         rsp_q.valid <= instr_gnt_o;
         if (instr_gnt_o) begin
            rsp_q.err  <= rd_err;
            rsp_q.data <= rd_err ? 32'h0 : mem[rd_idx];
         end
      end
   end

   instr_mem_delay_line #(
      .DEPTH(LATENCY - 1)
   ) u_delay (
      .clk (clk),
      .rst (rst),
      .d   (rsp_q),
      .q   (rsp_out)
   );

   assign instr_rvalid_o = rsp_out.valid;
   assign instr_rdata_o  = rsp_out.data;
   assign instr_err_o    = rsp_out.err;

   a_no_overgrant: assert property (@(posedge clk) disable iff (rst)
      !(instr_gnt_o && (outstanding == MAX_CNT)));

   a_no_underflow: assert property (@(posedge clk) disable iff (rst)
      !(instr_rvalid_o && (outstanding == '0)));

endmodule
